// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin arbiter slice.
//   arb_state_t      : FSM state encoding (IDLE = 1'b0, GRANT = 1'b1)
//   N_CLIENTS        : number of requesters served by the arbiter
//   MAX_HOLD_DEFAULT : default grant-hold limit for the optional timeout
//                      (only meaningful when ARB_TIMEOUT_EN is defined)
// -----------------------------------------------------------------------------
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int N_CLIENTS        = 4;
   localparam int MAX_HOLD_DEFAULT = 15;

endpackage : arb_pkg

// File: rtl/decoder_24.sv
// -----------------------------------------------------------------------------
// decoder_24
// 2-to-4 binary to one-hot decoder (purely combinational).
//   sel : input  [1:0] binary index
//   dec : output [3:0] one-hot image of sel (bit sel is set)
// -----------------------------------------------------------------------------
module decoder_24 (
   input  logic [1:0] sel,
   output logic [3:0] dec
);

   always_comb begin
      dec = 4'b0000;
      dec[sel] = 1'b1;
   end

endmodule : decoder_24

// File: rtl/arbiter_rr4.sv
// -----------------------------------------------------------------------------
// arbiter_rr4
// Four-requester round-robin arbiter for a single shared resource. One client
// at a time holds a one-hot grant until it signals completion or withdraws its
// request; priority then rotates so the client after the last one granted is
// searched first.
//
// Parameter MAX_HOLD: grant cycles before forced release (1..255), used only
// when ARB_TIMEOUT_EN is defined.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a hold counter forces release after MAX_HOLD grant cycles
//   and pulses timeout for one cycle. When undefined, no counter exists and
//   timeout is tied low.
//
// Ports:
//   clk     : input       system clock, rising-edge active
//   rst     : input       asynchronous active-high reset
//   req     : input  [3:0] request lines, bit i = client i
//   done    : input       completion pulse from the granted client
//   gnt     : output [3:0] one-hot grant, zero when idle
//   gnt_id  : output [1:0] index of the granted client, zero when idle
//   busy    : output      high while a grant is held (FSM in GRANT)
//   timeout : output      one-cycle pulse on a forced release
//
// Handshake: a client raises req[i] and keeps it high until served. When
// gnt[i] is seen high the client owns the resource; it ends ownership by
// pulsing done for one cycle or by dropping req[i]. Either ends the grant on
// that edge and gnt returns to zero for at least one cycle before the next
// grant. Requests from other clients are never allowed to preempt a grant.
// -----------------------------------------------------------------------------
module arbiter_rr4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT   // 1..255 grant cycles
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CLIENTS-1:0] req,
  input  logic                 done,
  output logic [N_CLIENTS-1:0] gnt,
  output logic [1:0]           gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic [1:0]           last_id;
  logic [1:0]           last_id_nxt;
  logic [1:0]           gnt_id_nxt;
  logic                 busy_nxt;
  logic [1:0]           pick_id;
  logic                 release_req;
  logic [N_CLIENTS-1:0] dec_out;

  // Walk last+1 .. last+4 (mod 4) and return the first requesting client.
  // The +4 step lands back on last itself, so a lone repeat requester is
  // still served.
  function automatic logic [1:0] rr_pick(input logic [N_CLIENTS-1:0] r,
                                         input logic [1:0]           last);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick_id     = rr_pick(req, last_id);
  // done and withdrawal together are a single release.
  assign release_req = done | ~req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic       timeout_nxt;
  logic       hold_expired;

  assign hold_expired = (hold_cnt == HOLD_LAST);

  // Cleared when a grant is issued, counts every cycle spent in GRANT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if (state == IDLE) begin
      if (|req) begin
        hold_cnt <= 8'd0;
      end
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt   = state;
    last_id_nxt = last_id;
    gnt_id_nxt  = gnt_id;
    busy_nxt    = busy;
`ifdef ARB_TIMEOUT_EN
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt   = GRANT;
          gnt_id_nxt  = pick_id;
          last_id_nxt = pick_id;
          busy_nxt    = 1'b1;
        end
      end
      GRANT: begin
        if (release_req) begin
          state_nxt  = IDLE;
          gnt_id_nxt = 2'd0;
          busy_nxt   = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        // A normal release on the same edge wins; no timeout pulse then.
        else if (hold_expired) begin
          state_nxt   = IDLE;
          gnt_id_nxt  = 2'd0;
          busy_nxt    = 1'b0;
          timeout_nxt = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt  = IDLE;
        gnt_id_nxt = 2'd0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_id <= 2'd3;   // client 0 searched first after reset
      gnt_id  <= 2'd0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_id <= last_id_nxt;
      gnt_id  <= gnt_id_nxt;
      busy    <= busy_nxt;
    end
  end

  decoder_24 u_gnt_dec (
    .sel (gnt_id),
    .dec (dec_out)
  );

  // gnt_id rests at 0 when idle, so the decode must be masked by busy.
  assign gnt = dec_out & {N_CLIENTS{busy}};

endmodule : arbiter_rr4

// File: tb/tb_arbiter_rr4.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr4
// Directed bench for arbiter_rr4. Expected grant indices are queued when a
// request pattern is driven and popped when the arbiter raises busy.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_arbiter_rr4;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  arbiter_rr4 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  // ---------------- checkers ----------------
  task automatic check(input string tag, input logic [3:0] eg,
                       input logic [1:0] eid, input logic eb, input logic et);
    n_tests++;
    assert ({gnt, gnt_id, busy, timeout} === {eg, eid, eb, et}) else begin
      n_fail++;
      $error("FAIL %s: observed gnt=%b id=%0d busy=%b timeout=%b, expected gnt=%b id=%0d busy=%b timeout=%b",
             tag, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, 4'b0000, 2'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [3:0] one_hot(input logic [1:0] id);
    logic [3:0] v;
    v = 4'b0000;
    v[id] = 1'b1;
    return v;
  endfunction

  // Wait up to budget falling edges for busy, then compare against the
  // oldest queued expectation.
  task automatic wait_grant(input string tag, input int budget);
    logic [1:0] e;
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!busy && c < budget);
    n_tests++;
    assert (busy === 1'b1) else begin
      n_fail++;
      $error("FAIL %s_wait: observed busy=%b after %0d cycles, expected busy=1", tag, busy, c);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
    check(tag, one_hot(e), e, 1'b1, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // single request, then done
    req = 4'b0100;
    exp_q.push_back(2'd2);
    wait_grant("single", 1);
    done = 1'b1;
    @(negedge clk);
    check_idle("single_done");
    done = 1'b1;            // done while idle must be ignored
    req  = 4'b0000;
    @(negedge clk);
    check_idle("done_in_idle");
    done = 1'b0;

    // rotation under full load from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back(2'(i % 4));
    for (int i = 0; i < 5; i++) begin
      wait_grant($sformatf("rot%0d", i), 1);
      @(negedge clk);
      check($sformatf("rot%0d_hold", i), one_hot(2'(i % 4)), 2'(i % 4), 1'b1, 1'b0);
      done = 1'b1;
      @(negedge clk);
      check_idle($sformatf("rot%0d_gap", i));
      done = 1'b0;
      if (i == 4) req = 4'b0000;
    end

    // fairness: last granted = 1, then 0 and 1 both request
    req = 4'b0010;
    exp_q.push_back(2'd1);
    wait_grant("fair_setup", 1);
    req  = 4'b0011;
    done = 1'b1;
    @(negedge clk);
    check_idle("fair_gap");
    done = 1'b0;
    exp_q.push_back(2'd0);
    wait_grant("fair_skip", 1);
    req = 4'b0000;
    @(negedge clk);
    check_idle("fair_release");

    // withdrawal without done
    req = 4'b1000;
    exp_q.push_back(2'd3);
    wait_grant("wd_grant", 1);
    @(negedge clk);
    check("wd_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    @(negedge clk);
    check_idle("withdraw");

    // asynchronous reset in the middle of a grant
    req = 4'b0100;
    exp_q.push_back(2'd2);
    wait_grant("ar_grant", 1);
    #2 rst = 1'b1;
    #1 check_idle("async_rst");
    req = 4'b0101;
    @(negedge clk);
    check_idle("in_reset");
    rst = 1'b0;
    exp_q.push_back(2'd0);
    wait_grant("after_rst", 1);
    req  = 4'b0000;
    done = 1'b1;
    @(negedge clk);
    check_idle("after_rst_rel");
    done = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // forced release after MAX_HOLD = 4 grant cycles
    req = 4'b0001;
    exp_q.push_back(2'd0);
    wait_grant("to_grant", 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("to_hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    @(negedge clk);
    check("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    exp_q.push_back(2'd0);
    wait_grant("to_regrant", 1);
    // done on the expiry edge wins over the timeout
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    check_idle("to_precedence");
    done = 1'b0;
    req  = 4'b0000;
`else
    // no timeout: grant is held indefinitely
    req = 4'b0001;
    exp_q.push_back(2'd0);
    wait_grant("hold_grant", 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    done = 1'b1;
    req  = 4'b0000;
    @(negedge clk);
    check_idle("hold_release");
    done = 1'b0;
`endif

    @(negedge clk);
    check_idle("final_idle");
    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain: observed %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_arbiter_rr4
